// File: rtl/pkt_rr_arbiter_pkg.sv
// Shared types and width defaults for the packet round-robin arbiter and its pickers.
package pkt_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DATA_W_DEF  = 256;
  localparam int TUSER_W_DEF = 128;
  localparam int KEEP_W_DEF  = DATA_W_DEF / 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or above ptr_i, wrapping modulo NUM_PORTS.
// Purely combinational, no latency, no backpressure.
module rr_pick #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]  req_i,
  input  logic [PORT_IDX_W-1:0] ptr_i,
  output logic [PORT_IDX_W-1:0] winner_o,
  output logic                  any_req_o
);

  localparam int SW = PORT_IDX_W + 1;

  logic [2*NUM_PORTS-1:0] req2;
  logic [NUM_PORTS-1:0]   rot;
  logic [SW-1:0]          off;
  logic [SW-1:0]          sum;

  // Doubling the request vector turns the wrap-around scan into a plain shift.
  assign req2 = {req_i, req_i};
  assign rot  = NUM_PORTS'(req2 >> ptr_i);

  always_comb begin
    off = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) off = SW'(i);
    end
  end

  assign sum       = {1'b0, ptr_i} + off;
  assign winner_o  = (sum >= SW'(NUM_PORTS)) ? PORT_IDX_W'(sum - SW'(NUM_PORTS))
                                             : PORT_IDX_W'(sum);
  assign any_req_o = |req_i;

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXIS inputs; 1-cycle latency, output stall drops granted tready.
// Define PKT_RR_ARBITER_STATS_EN to add per-port completed-packet counters on pkt_cnt.
module pkt_rr_arbiter
  import pkt_rr_arbiter_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = DATA_W_DEF,
  parameter int C_S_AXIS_TUSER_WIDTH = TUSER_W_DEF,
  parameter int NUM_PORTS            = 4,
  parameter int PORT_IDX_W           = $clog2(NUM_PORTS)
) (
  input  logic                                            clk,
  input  logic                                            aresetn,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [NUM_PORTS*(C_S_AXIS_DATA_WIDTH/8)-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]       s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                            s_axis_tlast,
  output logic [NUM_PORTS-1:0]                            s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]                m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
  output logic                                            m_axis_tvalid,
  output logic                                            m_axis_tlast,
  input  logic                                            m_axis_tready,
`ifdef PKT_RR_ARBITER_STATS_EN
  output logic [NUM_PORTS*32-1:0]                         pkt_cnt,
`endif
  output logic [PORT_IDX_W-1:0]                           grant_idx
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  state_e                state_q, state_d;
  logic [PORT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [NUM_PORTS-1:0]  grant_oh_q, grant_oh_d;

  logic [DW-1:0] tdata_q;
  logic [KW-1:0] tkeep_q;
  logic [UW-1:0] tuser_q;
  logic          tvalid_q;
  logic          tlast_q;

  logic [PORT_IDX_W-1:0] winner;
  logic                  any_req;
  logic                  out_free;
  logic                  accept;
  logic                  sel_vld;
  logic                  sel_last;
  logic [DW-1:0]         sel_data;
  logic [KW-1:0]         sel_keep;
  logic [UW-1:0]         sel_user;

  rr_pick #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_IDX_W (PORT_IDX_W)
  ) u_rr_pick (
    .req_i     (s_axis_tvalid),
    .ptr_i     (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // grant_oh_q is zero outside BUSY, so this mux selects nothing while arbitrating.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    sel_keep = '0;
    sel_user = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_oh_q[i]) begin
        sel_vld  = s_axis_tvalid[i];
        sel_last = s_axis_tlast[i];
        sel_data = s_axis_tdata[i*DW +: DW];
        sel_keep = s_axis_tkeep[i*KW +: KW];
        sel_user = s_axis_tuser[i*UW +: UW];
      end
    end
  end

  assign out_free      = ~tvalid_q | m_axis_tready;
  assign accept        = (state_q == BUSY) & sel_vld & out_free;
  assign s_axis_tready = ((state_q == BUSY) && out_free) ? grant_oh_q : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = BUSY;
          grant_oh_d  = NUM_PORTS'(1) << winner;
          grant_idx_d = winner;
          rr_ptr_d    = (winner == PORT_IDX_W'(NUM_PORTS - 1)) ? '0 : winner + PORT_IDX_W'(1);
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_d    = IDLE;
          grant_oh_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  // Output register keeps draining a tlast beat while the FSM re-arbitrates.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (accept) begin
      tdata_q  <= sel_data;
      tkeep_q  <= sel_keep;
      tuser_q  <= sel_user;
      tvalid_q <= 1'b1;
      tlast_q  <= sel_last;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign grant_idx     = grant_idx_q;

`ifdef PKT_RR_ARBITER_STATS_EN
  logic [NUM_PORTS-1:0][31:0] cnt_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (accept && sel_last) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_oh_q[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: queued per-port sources, logged output beats vs hand-computed tables.
module tb_pkt_rr_arbiter;
  import pkt_rr_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int IW = 2;

  logic              clk;
  logic              aresetn;
  logic [NP*DW-1:0]  s_axis_tdata;
  logic [NP*KW-1:0]  s_axis_tkeep;
  logic [NP*UW-1:0]  s_axis_tuser;
  logic [NP-1:0]     s_axis_tvalid;
  logic [NP-1:0]     s_axis_tlast;
  logic [NP-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [IW-1:0]     grant_idx;
`ifdef PKT_RR_ARBITER_STATS_EN
  logic [NP*32-1:0]  pkt_cnt;
`endif

  pkt_rr_arbiter #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .NUM_PORTS            (NP),
    .PORT_IDX_W           (IW)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
`ifdef PKT_RR_ARBITER_STATS_EN
    .pkt_cnt       (pkt_cnt),
`endif
    .grant_idx     (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_bad;
  int cyc_n;

  logic [7:0]  in_dat  [NP][$];
  bit          in_last [NP][$];
  logic [DW-1:0] out_dat  [$];
  logic [KW-1:0] out_keep [$];
  logic [UW-1:0] out_user [$];
  bit            out_last [$];
  int            out_cyc  [$];

  logic          mrdy;
  logic [NP-1:0] hs_pend;
  logic          m_hs_pend;
  logic [DW-1:0] pend_dat;
  logic [KW-1:0] pend_keep;
  logic [UW-1:0] pend_user;
  logic          pend_last;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add(input int p, input logic [7:0] d, input bit l);
    in_dat[p].push_back(d);
    in_last[p].push_back(l);
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (in_dat[p].size() != 0) begin
        s_axis_tvalid[p]           = 1'b1;
        s_axis_tlast[p]            = in_last[p][0];
        s_axis_tdata[p*DW +: DW]   = DW'(in_dat[p][0]);
        s_axis_tkeep[p*KW +: KW]   = KW'(in_dat[p][0]);
        s_axis_tuser[p*UW +: UW]   = UW'(in_dat[p][0]) + UW'(16'h1000);
      end else begin
        s_axis_tvalid[p]           = 1'b0;
        s_axis_tlast[p]            = 1'b0;
        s_axis_tdata[p*DW +: DW]   = '0;
        s_axis_tkeep[p*KW +: KW]   = '0;
        s_axis_tuser[p*UW +: UW]   = '0;
      end
    end
    m_axis_tready = mrdy;
  endtask

  task automatic clear_log();
    out_dat.delete();
    out_keep.delete();
    out_user.delete();
    out_last.delete();
    out_cyc.delete();
  endtask

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      in_dat[p].delete();
      in_last[p].delete();
    end
    hs_pend   = '0;
    m_hs_pend = 1'b0;
  endtask

  // One clock: retire handshakes of the edge, present new inputs, then sample.
  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
    for (int p = 0; p < NP; p++) begin
      if (hs_pend[p]) begin
        void'(in_dat[p].pop_front());
        void'(in_last[p].pop_front());
      end
    end
    if (m_hs_pend) begin
      out_dat.push_back(pend_dat);
      out_keep.push_back(pend_keep);
      out_user.push_back(pend_user);
      out_last.push_back(pend_last);
      out_cyc.push_back(cyc_n);
    end
    drive();
    #1;
    hs_pend   = s_axis_tvalid & s_axis_tready;
    m_hs_pend = m_axis_tvalid & m_axis_tready;
    pend_dat  = m_axis_tdata;
    pend_keep = m_axis_tkeep;
    pend_user = m_axis_tuser;
    pend_last = m_axis_tlast;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_src();
    clear_log();
    drive();
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int k = 0; k < budget && out_dat.size() < n; k++) step();
  endtask

  function automatic logic [DW-1:0] got_dat(input int i);
    return (i < out_dat.size()) ? out_dat[i] : '1;
  endfunction

  function automatic logic got_last(input int i);
    return (i < out_last.size()) ? out_last[i] : 1'bx;
  endfunction

  function automatic int got_cyc(input int i);
    return (i < out_cyc.size()) ? out_cyc[i] : -1000;
  endfunction

  task automatic check_beats(input string tag, input logic [7:0] d[], input bit l[]);
    check_eq({tag, "_cnt"}, 256'(out_dat.size()), 256'(d.size()));
    for (int i = 0; i < d.size(); i++) begin
      check_eq($sformatf("%s_dat%0d", tag, i), 256'(got_dat(i)), 256'(d[i]));
      check_eq($sformatf("%s_last%0d", tag, i), 256'(got_last(i)), 256'(l[i]));
    end
  endtask

  logic [NP-1:0] other_rdy;
  bit            seen;

  initial begin
    n_chk = 0;
    n_bad = 0;
    cyc_n = 0;
    mrdy  = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;

    // Reset values
    aresetn = 1'b0;
    clear_src();
    drive();
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    check_eq("rst_tdata",  256'(m_axis_tdata),  256'(0));
    check_eq("rst_tlast",  256'(m_axis_tlast),  256'(0));
    check_eq("rst_tkeep",  256'(m_axis_tkeep),  256'(0));
    check_eq("rst_tuser",  256'(m_axis_tuser),  256'(0));
    check_eq("rst_sready", 256'(s_axis_tready), 256'(0));
    check_eq("rst_gidx",   256'(grant_idx),     256'(0));
    @(posedge clk);
    #1 aresetn = 1'b1;

    // Port 2 alone, 3-beat packet
    add(2, 8'hA1, 0); add(2, 8'hA2, 0); add(2, 8'hA3, 1);
    other_rdy = '0;
    for (int k = 0; k < 20 && out_dat.size() < 3; k++) begin
      step();
      other_rdy |= s_axis_tready & 4'b1011;
    end
    repeat (2) step();
    check_beats("t1", '{8'hA1, 8'hA2, 8'hA3}, '{1'b0, 1'b0, 1'b1});
    check_eq("t1_gap1",  256'(got_cyc(1) - got_cyc(0)), 256'(1));
    check_eq("t1_gap2",  256'(got_cyc(2) - got_cyc(1)), 256'(1));
    check_eq("t1_gidx",  256'(grant_idx), 256'(2));
    check_eq("t1_other", 256'(other_rdy), 256'(0));
    check_eq("t1_keep",  256'((out_keep.size() > 2) ? out_keep[2] : '1), 256'(32'hA3));
    check_eq("t1_user",  256'((out_user.size() > 0) ? out_user[0] : '1), 256'(16'h10A1));

    // All ports valid, 2-beat packets, port 0 has two
    do_reset();
    add(0, 8'h00, 0); add(0, 8'h01, 1); add(0, 8'h02, 0); add(0, 8'h03, 1);
    add(1, 8'h10, 0); add(1, 8'h11, 1);
    add(2, 8'h20, 0); add(2, 8'h21, 1);
    add(3, 8'h30, 0); add(3, 8'h31, 1);
    run_until(10, 80);
    repeat (3) step();
    check_beats("t2", '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03},
                      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    for (int i = 1; i < 10; i++)
      check_eq($sformatf("t2_gap%0d", i), 256'(got_cyc(i) - got_cyc(i - 1)), 256'((i % 2 == 1) ? 1 : 2));

    // Downstream stall for 5 cycles mid-packet on port 1
    clear_log();
    add(1, 8'hB1, 0); add(1, 8'hB2, 0); add(1, 8'hB3, 0); add(1, 8'hB4, 1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = m_axis_tvalid && (m_axis_tdata[7:0] == 8'hB2);
    end
    check_eq("t3_reach", 256'(seen), 256'(1));
    mrdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("t3_hold_dat%0d", k), 256'(m_axis_tdata), 256'(8'hB3));
      check_eq($sformatf("t3_hold_vld%0d", k), 256'(m_axis_tvalid), 256'(1));
      check_eq($sformatf("t3_hold_rdy%0d", k), 256'(s_axis_tready), 256'(0));
    end
    mrdy = 1'b1;
    run_until(4, 20);
    repeat (3) step();
    check_beats("t3", '{8'hB1, 8'hB2, 8'hB3, 8'hB4}, '{1'b0, 1'b0, 1'b0, 1'b1});

    // Simultaneous single-beat packets on ports 1 and 3, pointer at 2
    check_eq("t4_ptr_pre", 256'(dut.rr_ptr_q), 256'(2));
    clear_log();
    add(1, 8'hC1, 1);
    add(3, 8'hC3, 1);
    run_until(2, 20);
    repeat (3) step();
    check_beats("t4", '{8'hC3, 8'hC1}, '{1'b1, 1'b1});
    check_eq("t4_ptr_post", 256'(dut.rr_ptr_q), 256'(2));

    // Reset during beat 2 of a 4-beat packet, then a clean packet
    clear_log();
    add(0, 8'hD1, 0); add(0, 8'hD2, 0); add(0, 8'hD3, 0); add(0, 8'hD4, 1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = m_axis_tvalid && (m_axis_tdata[7:0] == 8'hD2);
    end
    check_eq("t5_reach", 256'(seen), 256'(1));
    aresetn = 1'b0;
    clear_src();
    clear_log();
    drive();
    #1;
    check_eq("t5_tvalid", 256'(m_axis_tvalid), 256'(0));
    check_eq("t5_tdata",  256'(m_axis_tdata),  256'(0));
    check_eq("t5_tlast",  256'(m_axis_tlast),  256'(0));
    check_eq("t5_tkeep",  256'(m_axis_tkeep),  256'(0));
    check_eq("t5_tuser",  256'(m_axis_tuser),  256'(0));
    check_eq("t5_sready", 256'(s_axis_tready), 256'(0));
    check_eq("t5_gidx",   256'(grant_idx),     256'(0));
    check_eq("t5_state",  256'(dut.state_q),   256'(IDLE));
    check_eq("t5_ptr",    256'(dut.rr_ptr_q),  256'(0));
    @(posedge clk);
    #1 aresetn = 1'b1;
    add(0, 8'hE1, 0); add(0, 8'hE2, 1);
    run_until(2, 20);
    repeat (3) step();
    check_beats("t5", '{8'hE1, 8'hE2}, '{1'b0, 1'b1});
    check_eq("t5_gidx_post", 256'(grant_idx), 256'(0));

`ifdef PKT_RR_ARBITER_STATS_EN
    // Counter wrap on port 0
    do_reset();
    force dut.cnt_q = {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
    step();
    release dut.cnt_q;
    add(0, 8'hF1, 1);
    run_until(1, 20);
    repeat (3) step();
    check_eq("st_cnt0",  256'(pkt_cnt[31:0]),   256'(0));
    check_eq("st_other", 256'(pkt_cnt[127:32]), 256'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_PORTS AXI-Stream sources into one master stream feeding the pipeline ingress (packet filter stage).
- Once a port is granted, it keeps the output until its tlast beat is accepted, so packets are never interleaved.
- Output is registered: one data register stage with a ready-based stall.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width per port.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width per port.
- NUM_PORTS, 4, number of slave inputs; legal range 2..8.
- PORT_IDX_W, $clog2(NUM_PORTS), width of the port index.

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  flattened; port i at slice [i*W +: W].
- s_axis_tkeep  in  NUM_PORTS*(C_S_AXIS_DATA_WIDTH/8)  flattened.
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  flattened.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  merged data.
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  merged keep.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  merged user.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged last.
- m_axis_tready  in  1  downstream ready.
- grant_idx  out  PORT_IDX_W  current or last granted port (debug).

Behaviour:
- Reset, asynchronous on aresetn low:
  - state=IDLE, rr_ptr=0, grant_oh=0, grant_idx=0.
  - All m_axis_* outputs 0; s_axis_tready all 0.
- State machine:
  - IDLE:
    - If any s_axis_tvalid bit is set, pick the first valid port scanning from rr_ptr upward modulo NUM_PORTS.
    - Register grant_oh and grant_idx, set rr_ptr = (winner+1) mod NUM_PORTS, go to BUSY.
    - If no valid bit is set, stay in IDLE; rr_ptr is unchanged.
  - BUSY:
    - s_axis_tready[i] = grant_oh[i] & (~m_axis_tvalid | m_axis_tready). All other ports see 0.
    - On an accepted beat (granted valid & ready), copy tdata/tkeep/tuser/tlast into the m_axis_* registers and set m_axis_tvalid=1.
    - If the accepted beat has tlast=1, go to IDLE and clear grant_oh.
    - If m_axis_tready=1 and no new beat is accepted, m_axis_tvalid goes to 0.
    - If m_axis_tready=0 while m_axis_tvalid=1, all m_axis_* outputs hold stable.
- Timing:
  - Latency is 1 cycle from input acceptance to m_axis_tvalid.
  - Each packet costs one arbitration bubble cycle (in IDLE); sustained throughput is 1 beat/cycle within a packet.
  - The output register may still be draining the previous tlast beat while IDLE arbitrates; IDLE never touches the m_axis_* registers.
- Boundary conditions:
  - Single-beat packet (tvalid & tlast on the first beat): accepted, then straight back to IDLE.
  - A granted port drops tvalid mid-packet: the grant is held, no timeout.
  - A non-granted port asserts tvalid while another port is BUSY: it waits; its ready stays 0.
  - All ports valid continuously: grants rotate 0,1,2,3,0...
  - rr_ptr wraps from NUM_PORTS-1 to 0.
  - Reset mid-packet: the partial packet is discarded on the output side; the upstream source is responsible for its own recovery.
  - m_axis_tkeep/tuser change only on accepted beats.

Optional Feature:
- Macro: PKT_RR_ARBITER_STATS_EN.
- When defined:
  - Adds output pkt_cnt (NUM_PORTS*32, flattened).
  - Per-port 32-bit counter increments when that port's tlast beat is accepted.
  - Counters wrap 0xFFFFFFFF -> 0 and reset to 0.
- When undefined: no counters and no pkt_cnt port; behaviour is otherwise identical.

Decomposition:
- Shared package/header:
  - State encodings IDLE=0, BUSY=1.
  - Width defaults: 256, 128, and keep width 32.
- One sub-module: rr_pick.
  - Combinational: inputs req[NUM_PORTS] and ptr; outputs winner index and any_req.
  - Reused by future schedulers.

Test Plan:
- Port 2 only sends a 3-beat packet (tdata 0xA1, 0xA2, 0xA3; tlast on beat 3) with m_axis_tready=1:
  - m_axis shows 0xA1..0xA3 on consecutive cycles, tlast with 0xA3.
  - grant_idx=2; s_axis_tready[0,1,3] stays 0 throughout.
- Ports 0..3 all valid with 2-beat packets:
  - Output packet order 0,1,2,3,0.
  - Exactly one IDLE bubble between packets; no interleaved beats.
- m_axis_tready held 0 for 5 cycles mid-packet:
  - m_axis_tdata/tvalid stable and s_axis_tready[granted]=0 during the stall.
  - No beat lost or duplicated after release.
- Single-beat packets on ports 1 and 3 simultaneously with rr_ptr=2:
  - Port 3 is granted first, then port 1; rr_ptr ends at 2.
- aresetn pulsed low during beat 2 of a 4-beat packet:
  - All outputs 0 immediately; state IDLE, rr_ptr=0.
  - A next packet from port 0 passes cleanly.
- With PKT_RR_ARBITER_STATS_EN, port-0 counter preloaded to 0xFFFFFFFF:
  - One port-0 packet -> pkt_cnt[0]=0; other counters unchanged.
